// File: rtl/pulse_scheduler.sv
// pulse_scheduler: NUM_REQ requesters share one down-counter. A round-robin
// arbiter grants one request in IDLE, the granted delay is latched and counted
// down, and a single-cycle one-hot pulse returns to the owner.
module pulse_scheduler #(
  parameter  int NUM_REQ = 4,
  parameter  int WIDTH   = 4,
  localparam int IW      = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_delay,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [NUM_REQ-1:0]       pulse,
  output logic                     busy,
  output logic [IW-1:0]            owner
);

  typedef enum logic [1:0] {IDLE, COUNT, PULSE} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  cnt_q, cnt_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic [IW-1:0]     rr_q, rr_d;

  logic [NUM_REQ-1:0][WIDTH-1:0] dly;
  logic [IW-1:0]                 sel;
  logic                          gnt_vld;
  logic                          accept;

  assign dly = req_delay;

  // Round-robin search starting at rr_q; the loop runs downward so the
  // closest valid index to rr_q is the one left in sel.
  always_comb begin
    logic [IW-1:0] idx;
    idx     = '0;
    sel     = '0;
    gnt_vld = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = rr_q + IW'(k);
      if (req_valid[idx]) begin
        gnt_vld = 1'b1;
        sel     = idx;
      end
    end
  end

  // Ready only in IDLE and outside reset, so a reset edge never sees an accept.
  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && rst && gnt_vld) req_ready[sel] = 1'b1;
  end

  assign accept = |(req_valid & req_ready);

  // Next-state logic: load on accept, count down to zero, one PULSE cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = COUNT;
          cnt_d   = dly[sel];
          owner_d = sel;
          rr_d    = sel + IW'(1);
        end
      end
      COUNT: begin
        if (cnt_q == '0) state_d = PULSE;
        else             cnt_d   = cnt_q - WIDTH'(1);
      end
      PULSE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      owner_q <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
    end
  end

  // Pulse decode from registered state; suppressed while reset is held.
  always_comb begin
    pulse = '0;
    if (state_q == PULSE && rst) pulse[owner_q] = 1'b1;
  end

  assign busy  = (state_q != IDLE);
  assign owner = owner_q;

endmodule

// File: tb/tb_pulse_scheduler.sv
// Directed bench for pulse_scheduler (NUM_REQ=4, WIDTH=4). Inputs change and
// outputs are sampled 1 time unit after each rising edge.
module tb_pulse_scheduler;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [15:0] req_delay;
  logic [3:0]  req_ready;
  logic [3:0]  pulse;
  logic        busy;
  logic [1:0]  owner;

  int n_cmp = 0;
  int n_err = 0;

  pulse_scheduler #(.NUM_REQ(4), .WIDTH(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_delay(req_delay),
    .req_ready(req_ready), .pulse(pulse), .busy(busy), .owner(owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; req_valid = 4'b0000; req_delay = 16'h0000;
    tick(); tick();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_cmp++; if (pulse !== 4'b0000) begin n_err++; $display("FAIL reset_pulse got %b exp 0000", pulse); end
    n_cmp++; if (owner !== 2'd0) begin n_err++; $display("FAIL reset_owner got %0d exp 0", owner); end
    req_valid = 4'b0100; #1;
    n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_ready got %b exp 0000", req_ready); end
    rst = 1'b1; #1;
    n_cmp++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL post_reset_ready got %b exp 0100", req_ready); end
    req_valid = 4'b0000;
  endtask

  task automatic test_single();
    logic [3:0] ep;
    req_delay[3:0] = 4'd3; req_valid = 4'b0001; #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL single_ready got %b exp 0001", req_ready); end
    tick();
    req_valid = 4'b0000;
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy0 got %b exp 1", busy); end
    for (int k = 1; k <= 5; k++) begin
      tick();
      ep = (k == 4) ? 4'b0001 : 4'b0000;
      n_cmp++; if (pulse !== ep) begin n_err++; $display("FAIL single_pulse k=%0d got %b exp %b", k, pulse, ep); end
      n_cmp++; if (busy !== (k <= 4)) begin n_err++; $display("FAIL single_busy k=%0d got %b exp %b", k, busy, (k <= 4)); end
    end
  endtask

  task automatic test_zero_max();
    logic [3:0] ep;
    req_delay[11:8] = 4'd0; req_valid = 4'b0100;
    tick();
    req_valid = 4'b0000;
    tick();
    n_cmp++; if (pulse !== 4'b0100) begin n_err++; $display("FAIL zero_pulse got %b exp 0100", pulse); end
    n_cmp++; if (owner !== 2'd2) begin n_err++; $display("FAIL zero_owner got %0d exp 2", owner); end
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL zero_idle got %b exp 0", busy); end
    req_delay[11:8] = 4'd15; req_valid = 4'b0100;
    tick();
    req_valid = 4'b0000;
    for (int k = 1; k <= 16; k++) begin
      tick();
      ep = (k == 16) ? 4'b0100 : 4'b0000;
      n_cmp++; if (pulse !== ep) begin n_err++; $display("FAIL max_pulse k=%0d got %b exp %b", k, pulse, ep); end
    end
    n_cmp++; if (owner !== 2'd2) begin n_err++; $display("FAIL max_owner got %0d exp 2", owner); end
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL max_idle got %b exp 0", busy); end
  endtask

  task automatic test_round_robin();
    int order [5] = '{0, 1, 2, 3, 0};
    logic [3:0] oh;
    rst = 1'b0; tick(); rst = 1'b1;
    req_delay = 16'h1111; req_valid = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      oh = 4'b0001 << order[g];
      #1;
      n_cmp++; if (req_ready !== oh) begin n_err++; $display("FAIL rr_ready g=%0d got %b exp %b", g, req_ready, oh); end
      tick();
      n_cmp++; if (owner !== 2'(order[g])) begin n_err++; $display("FAIL rr_owner g=%0d got %0d exp %0d", g, owner, order[g]); end
      tick(); tick();
      n_cmp++; if (pulse !== oh) begin n_err++; $display("FAIL rr_pulse g=%0d got %b exp %b", g, pulse, oh); end
      tick();
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rr_idle g=%0d got %b exp 0", g, busy); end
    end
    req_valid = 4'b0000;
  endtask

  task automatic test_latch();
    logic [3:0] ep;
    req_delay[7:4] = 4'd5; req_valid = 4'b0010; #1;
    n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL latch_ready got %b exp 0010", req_ready); end
    tick();
    req_valid = 4'b0000; req_delay[7:4] = 4'd0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      ep = (k == 6) ? 4'b0010 : 4'b0000;
      n_cmp++; if (pulse !== ep) begin n_err++; $display("FAIL latch_pulse k=%0d got %b exp %b", k, pulse, ep); end
    end
    tick();
  endtask

  task automatic test_reset_mid();
    req_delay[3:0] = 4'd8; req_valid = 4'b0001;
    tick();
    req_valid = 4'b0000;
    tick(); tick();
    rst = 1'b0;
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_busy got %b exp 0", busy); end
    n_cmp++; if (pulse !== 4'b0000) begin n_err++; $display("FAIL mid_pulse got %b exp 0000", pulse); end
    rst = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      n_cmp++; if (pulse !== 4'b0000) begin n_err++; $display("FAIL mid_nopulse k=%0d got %b exp 0000", k, pulse); end
    end
    req_delay[7:4] = 4'd0; req_delay[15:12] = 4'd0; req_valid = 4'b1010; #1;
    n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL mid_ready got %b exp 0010", req_ready); end
    tick();
    req_valid = 4'b0000;
    n_cmp++; if (owner !== 2'd1) begin n_err++; $display("FAIL mid_owner got %0d exp 1", owner); end
    tick(); tick();
  endtask

  task automatic test_blocking();
    req_delay[3:0] = 4'd2; req_delay[15:12] = 4'd1; req_valid = 4'b0001;
    tick();
    req_valid = 4'b1000;
    for (int k = 1; k <= 3; k++) begin
      #1;
      n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL block_ready k=%0d got %b exp 0000", k, req_ready); end
      tick();
    end
    n_cmp++; if (pulse !== 4'b0001) begin n_err++; $display("FAIL block_pulse0 got %b exp 0001", pulse); end
    n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL block_ready_pulse got %b exp 0000", req_ready); end
    tick();
    n_cmp++; if (req_ready !== 4'b1000) begin n_err++; $display("FAIL block_ready_idle got %b exp 1000", req_ready); end
    tick();
    req_valid = 4'b0000;
    n_cmp++; if (owner !== 2'd3) begin n_err++; $display("FAIL block_owner got %0d exp 3", owner); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL block_busy got %b exp 1", busy); end
    tick(); tick();
    n_cmp++; if (pulse !== 4'b1000) begin n_err++; $display("FAIL block_pulse3 got %b exp 1000", pulse); end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_zero_max();
    test_round_robin();
    test_latch();
    test_reset_mid();
    test_blocking();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pulse_scheduler.md
PULSE_SCHEDULER -- requirements
Module: pulse_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing the single delay counter (power of two, 2..8).
REQ-002 Parameter WIDTH, default 4, bit width of each requested delay.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 rst  input  1  synchronous, active-low reset; rst==0 at a posedge clk resets the block.
REQ-005 req_valid  input  NUM_REQ  bit i high = requester i asks for a pulse.
REQ-006 req_delay  input  NUM_REQ*WIDTH  slice [i*WIDTH +: WIDTH] = delay d_i for requester i; unsigned.
REQ-007 req_ready  output  NUM_REQ  bit i high = request i is accepted at this edge if req_valid[i] is high.
REQ-008 pulse  output  NUM_REQ  one-hot, single-cycle pulse to the owning requester.
REQ-009 busy  output  1  high whenever the counter is owned (state != IDLE).
REQ-010 owner  output  log2(NUM_REQ)  index of the current or most recent owner.

Function
REQ-011 The block SHALL implement three states: IDLE, COUNT and PULSE.
REQ-012 In IDLE, the arbiter SHALL select the first i with req_valid[i]==1, searching round-robin from rr_ptr upward (mod NUM_REQ).
REQ-013 req_ready SHALL be combinational, one-hot on the selected index in IDLE, and all-zero in COUNT and PULSE or when no req_valid bit is set.
REQ-014 Accept = req_valid[i] & req_ready[i] at a posedge.
REQ-015 On accept, the block SHALL load cnt <= d_i, set owner <= i, set rr_ptr <= (i+1) mod NUM_REQ, and move to COUNT.
REQ-016 In COUNT, if cnt==0 the block SHALL move to PULSE; otherwise it SHALL decrement cnt and stay in COUNT.
REQ-017 The pulse[owner] bit SHALL be high for exactly the one cycle spent in PULSE, and all other pulse bits SHALL be 0.
REQ-018 From PULSE the block SHALL always return to IDLE on the next edge.
REQ-019 Latency: an accept at edge E0 SHALL put the block in PULSE after edge E0+d+1, so pulse is high during the cycle between E0+d+1 and E0+d+2.
REQ-020 d=0 SHALL give a latency of 1 edge, and d=2^WIDTH-1 (15) SHALL give a latency of 16 edges; cnt SHALL never wrap.
REQ-021 The minimum spacing between consecutive accepts is d+3 cycles; new requests SHALL wait in IDLE only.
REQ-022 Changes to req_valid or req_delay after accept SHALL NOT affect the pending pulse, and the owner's delay SHALL be latched.
REQ-023 A requester that deasserts valid before acceptance SHALL NOT be granted and SHALL leave rr_ptr unchanged.
REQ-024 busy SHALL equal (state != IDLE) and SHALL be derived from registered state.
REQ-025 owner SHALL retain its last value while in IDLE.
REQ-026 Requests from multiple requesters in the same cycle SHALL be resolved by the rr_ptr rule only; no requester SHALL wait more than NUM_REQ-1 grants once it holds valid continuously.

Reset
REQ-027 While rst==0, at the edge the block SHALL set state=IDLE, cnt=0, rr_ptr=0 and owner=0.
REQ-028 Consequently, during reset pulse SHALL be 0, busy SHALL be 0, and req_ready SHALL NOT produce an accept.
REQ-029 Reset asserted in COUNT or PULSE SHALL abort the operation with no pulse emitted, including in the cycle after the reset edge.
REQ-030 The first arbitration after reset SHALL start from index 0.

Verification
REQ-031 Single request: rst pulse, then req_valid=4'b0001 with d_0=3, accepted at E0 -> pulse=4'b0001 only between E0+4 and E0+5, busy high E0..E0+5, then IDLE.
REQ-032 Zero/max delay: d_2=0 gives a pulse 1 edge after accept; d_2=15 gives a pulse 16 edges after accept; owner=2 in both cases.
REQ-033 Round robin: req_valid=4'b1111 held with all d=1 -> grant order 0,1,2,3,0; each pulse is one-hot to its owner, and accepts are 4 cycles apart.
REQ-034 Latching: accept r1 with d=5, then change d_1 to 0 and drop req_valid[1] during COUNT -> the pulse still arrives 6 edges after accept.
REQ-035 Reset mid-operation: accept d=8 and drive rst=0 at E0+3 -> no pulse, busy=0, and the next grant with req_valid=4'b1010 goes to index 1.
REQ-036 Blocking: req_valid[3] raised while busy -> req_ready stays 0 until IDLE, then requester 3 is accepted on the first IDLE edge.
